// File: rtl/counter10k_arbiter_if.sv
// Requester-side bus of the shared interval-counter arbiter.
// The master drives requests; the slave (the arbiter) returns grant/done/status.
interface counter10k_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*PW-1:0] req_periods;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [PW-1:0]      periods_left;

    modport master (
        output req, req_periods,
        input  grant, done, busy, periods_left
    );

    modport slave (
        input  req, req_periods,
        output grant, done, busy, periods_left
    );
endinterface

// File: rtl/counter10k_arbiter.sv
// Round-robin owner of one counter10k instance: runs the counter for the
// granted requester's period count, pulses done, then hands over.
module counter10k_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 4
) (
    input  logic                 tick,
    input  logic                 reset,
    counter10k_arbiter_if.slave  bus,
    output logic                 counter_run,
    input  logic                 counter_reached
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   periods_left_q, periods_left_d;
    logic            run_q, run_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;

    logic [PW-1:0]   periods_arr [NREQ];
    logic            win_found_c;
    logic [IW-1:0]   win_idx_c;
    logic [IW-1:0]   cand_c;
    logic [IW-1:0]   owner_next_c;
    logic            final_c;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            periods_arr[i] = bus.req_periods[i*PW +: PW];
        end
    end

    // First pending request at or after the rotating pointer.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand_c = IW'((int'(ptr_q) + k) % int'(NREQ));
            if (!win_found_c && bus.req[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    assign owner_next_c = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
    assign final_c      = counter_reached && (periods_left_q == PW'(1));

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        done_d         = '0;
        busy_d         = busy_q;
        periods_left_d = periods_left_q;
        run_d          = run_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;

        unique case (state_q)
            S_IDLE: begin
                grant_d        = '0;
                busy_d         = 1'b0;
                periods_left_d = '0;
                run_d          = 1'b0;
                if (win_found_c) begin
                    state_d        = S_RUN;
                    owner_d        = win_idx_c;
                    grant_d        = NREQ'(1) << win_idx_c;
                    busy_d         = 1'b1;
                    run_d          = 1'b1;
                    periods_left_d = (periods_arr[win_idx_c] == '0) ? PW'(1)
                                                                    : periods_arr[win_idx_c];
                end
            end
            S_RUN: begin
                run_d  = 1'b1;
                busy_d = 1'b1;
                // Completion takes priority over a request dropped on the same tick.
                if (final_c) begin
                    state_d        = S_DONE;
                    done_d         = NREQ'(1) << owner_q;
                    run_d          = 1'b0;
                    periods_left_d = '0;
                    ptr_d          = owner_next_c;
                end else if (!bus.req[owner_q]) begin
                    state_d        = S_IDLE;
                    grant_d        = '0;
                    busy_d         = 1'b0;
                    run_d          = 1'b0;
                    periods_left_d = '0;
                    ptr_d          = owner_next_c;
                end else if (counter_reached) begin
                    periods_left_d = periods_left_q - PW'(1);
                end
            end
            S_DONE: begin
                state_d        = S_IDLE;
                grant_d        = '0;
                busy_d         = 1'b0;
                run_d          = 1'b0;
                periods_left_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                run_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge tick) begin
        if (reset) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            done_q         <= '0;
            busy_q         <= 1'b0;
            periods_left_q <= '0;
            run_q          <= 1'b0;
            ptr_q          <= '0;
            owner_q        <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            periods_left_q <= periods_left_d;
            run_q          <= run_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.periods_left = periods_left_q;
    assign counter_run      = run_q;
endmodule

// File: tb/tb_counter10k_arbiter.sv
// Scoreboard bench for counter10k_arbiter with a 5-tick counter10k model.
module tb_counter10k_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned PW   = 4;
    localparam int EV_GRANT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    logic tick  = 1'b0;
    logic reset = 1'b1;
    logic counter_run;
    logic counter_reached;

    counter10k_arbiter_if #(.NREQ(NREQ), .PW(PW)) bus ();

    counter10k_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
        .tick           (tick),
        .reset          (reset),
        .bus            (bus),
        .counter_run    (counter_run),
        .counter_reached(counter_reached)
    );

    always #5 tick = ~tick;

    // counter10k model: reached once every 5 ticks of run, cleared when run is low
    int cnt = 0;
    always @(posedge tick) begin
        if (!counter_run) cnt <= 0;
        else              cnt <= (cnt == 4) ? 0 : cnt + 1;
    end
    assign counter_reached = counter_run && (cnt == 4);

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int kind;
        int idx;
        int val;
    } ev_t;
    ev_t exp_q[$];

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        if (!$onehot(v)) return 99;
        for (int i = 0; i < int'(NREQ); i++) if (v[i]) return i;
        return 99;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int k, input int i, input int v);
        ev_t e;
        e.kind = k;
        e.idx  = i;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic sb_observe(input int k, input int i, input int v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got kind=%0d idx=%0d val=%0d expected no event at %0t",
                     k, i, v, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.idx != i || e.val != v) begin
                n_bad++;
                $display("FAIL sb_event: got kind=%0d idx=%0d val=%0d expected kind=%0d idx=%0d val=%0d at %0t",
                         k, i, v, e.kind, e.idx, e.val, $time);
            end
        end
    endtask

    // Monitor: turns grant/done activity into events and run-length measurements.
    logic [NREQ-1:0] prev_grant = '0;
    logic [NREQ-1:0] prev_done  = '0;
    int run_cnt = 0;
    initial begin
        forever begin
            @(negedge tick);
            if (bus.grant != '0 && prev_grant == '0) begin
                run_cnt = counter_run ? 1 : 0;
                sb_observe(EV_GRANT, onehot_idx(bus.grant), int'(bus.periods_left));
            end else if (bus.grant != '0 && counter_run) begin
                run_cnt++;
            end
            if (bus.done != '0)
                sb_observe(EV_DONE, onehot_idx(bus.done), run_cnt);
            if (bus.grant == '0 && prev_grant != '0 && prev_done == '0)
                sb_observe(EV_ABORT, onehot_idx(prev_grant), run_cnt);
            prev_grant = bus.grant;
            prev_done  = bus.done;
        end
    end

    task automatic outs_zero(input string nm);
        check(nm, int'({bus.grant, bus.done, bus.busy, bus.periods_left, counter_run}), 0);
    endtask

    task automatic wait_grant(input int b, input string nm);
        int n = 0;
        while (!bus.grant[b] && n < 200) begin
            @(negedge tick);
            n++;
        end
        if (!bus.grant[b]) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input int ndone, input string nm);
        int seen = 0;
        int n = 0;
        while (seen < ndone && n < 500) begin
            @(negedge tick);
            n++;
            if (bus.done != '0) seen++;
        end
        if (seen < ndone) check({nm, "_timeout"}, seen, ndone);
    endtask

    task automatic wait_reached(input int nr, input string nm);
        int seen = 0;
        int n = 0;
        while (seen < nr && n < 200) begin
            @(negedge tick);
            n++;
            if (counter_reached) seen++;
        end
        if (seen < nr) check({nm, "_timeout"}, seen, nr);
    endtask

    initial begin
        bus.req         = 4'b1111;
        bus.req_periods = '0;
        reset           = 1'b1;

        // reset dominates pending requests
        repeat (3) begin
            @(negedge tick);
            outs_zero("t1_reset");
        end
        bus.req = '0;
        reset   = 1'b0;

        // single requester, 3 periods
        @(negedge tick);
        bus.req_periods = 16'h0300;
        bus.req         = 4'b0100;
        expect_ev(EV_GRANT, 2, 3);
        expect_ev(EV_DONE, 2, 15);
        @(negedge tick);
        check("t2_latency", int'(bus.grant), 4);
        wait_done(1, "t2_done");
        bus.req = '0;
        repeat (3) @(negedge tick);
        outs_zero("t2_idle");

        // reset pointer, then full round-robin with 1 period each
        reset = 1'b1;
        @(negedge tick);
        outs_zero("t3_reset");
        reset           = 1'b0;
        bus.req_periods = 16'h1111;
        bus.req         = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            expect_ev(EV_GRANT, i % 4, 1);
            expect_ev(EV_DONE, i % 4, 5);
        end
        wait_done(5, "t3_done");
        bus.req = '0;
        repeat (3) @(negedge tick);

        // abort by owner 1 while 2 waits
        bus.req_periods = 16'h0240;
        bus.req         = 4'b0110;
        expect_ev(EV_GRANT, 1, 4);
        expect_ev(EV_ABORT, 1, 8);
        expect_ev(EV_GRANT, 2, 2);
        expect_ev(EV_DONE, 2, 10);
        wait_grant(1, "t4_grant");
        repeat (7) @(negedge tick);
        bus.req[1] = 1'b0;
        @(negedge tick);
        check("t4_abort_grant", int'(bus.grant), 0);
        check("t4_abort_run", int'(counter_run), 0);
        wait_done(1, "t4_done");
        bus.req = '0;
        repeat (3) @(negedge tick);

        // request drops on the same tick as the final reached
        bus.req_periods = 16'h2000;
        bus.req         = 4'b1000;
        expect_ev(EV_GRANT, 3, 2);
        expect_ev(EV_DONE, 3, 10);
        wait_grant(3, "t5_grant");
        wait_reached(2, "t5_reached");
        bus.req = '0;
        wait_done(1, "t5_done");
        repeat (3) @(negedge tick);

        // zero periods behaves as one
        bus.req_periods = '0;
        bus.req         = 4'b0001;
        expect_ev(EV_GRANT, 0, 1);
        expect_ev(EV_DONE, 0, 5);
        wait_done(1, "t6a_done");
        bus.req = '0;
        repeat (3) @(negedge tick);

        // reset in the middle of a run
        bus.req_periods = 16'h0030;
        bus.req         = 4'b0010;
        expect_ev(EV_GRANT, 1, 3);
        expect_ev(EV_ABORT, 1, 8);
        wait_grant(1, "t6b_grant");
        repeat (7) @(negedge tick);
        reset   = 1'b1;
        bus.req = '0;
        @(negedge tick);
        outs_zero("t6b_reset");
        reset = 1'b0;
        repeat (4) @(negedge tick);
        outs_zero("t6b_idle");

        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
